// File: rtl/slave_buffer.sv
// Receive-side byte FIFO (first-word-fall-through) between the master link and a local consumer.
// Optional accepted-byte counter enabled by defining SLAVE_BUFFER_RXCNT_EN.
module slave_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          m_valid,
    input  logic [7:0]    m_s_data,
    output logic          s_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic [15:0]   rx_count
);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ALMOST = LVL_FULL - LVL_ONE;
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   w_level_next;
    logic [7:0]    r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    // Handshake qualifiers; outputs themselves depend on registers only.
    assign s_ready   = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_mem[r_rd_ptr];
    assign level     = r_level;
    assign w_push    = m_valid && s_ready;
    assign w_pop     = out_ready && out_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_push) w_state_next = PARTIAL;
            end
            PARTIAL: begin
                if (w_push && !w_pop && (r_level == LVL_ALMOST)) begin
                    w_state_next = FULL;
                end else if (w_pop && !w_push && (r_level == LVL_ONE)) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) w_state_next = PARTIAL;
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_ONE;
            2'b01:   w_level_next = r_level - LVL_ONE;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= EMPTY;
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= m_s_data;
    end

`ifdef SLAVE_BUFFER_RXCNT_EN
    logic [15:0] r_rx_count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rx_count <= '0;
        end else if (w_push) begin
            r_rx_count <= r_rx_count + 16'd1;
        end
    end

    assign rx_count = r_rx_count;
`else
    assign rx_count = 16'h0000;
`endif

endmodule

// File: tb/tb_slave_buffer.sv
// Self-checking bench for slave_buffer: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_slave_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          nrst;
    logic          m_valid;
    logic [7:0]    m_s_data;
    logic          s_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic [AW:0]   level;
    logic [15:0]   rx_count;

    int n_checks;
    int n_fail;

    logic [7:0]  model_q[$];
    int unsigned model_cnt;

    typedef struct {
        logic       mv;
        logic [7:0] d;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        int         el;
        logic       esr;
    } vec_t;

    vec_t vecs[$];

    slave_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .m_valid   (m_valid),
        .m_s_data  (m_s_data),
        .s_ready   (s_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .rx_count  (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rx(input int unsigned cnt);
`ifdef SLAVE_BUFFER_RXCNT_EN
        return cnt[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic compare_model();
        check("s_ready", 32'(s_ready), 32'(model_q.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        check("level", 32'(level), 32'(model_q.size()));
        check("rx_count", 32'(rx_count), 32'(exp_rx(model_cnt)));
        if (model_q.size() > 0) check("out_data", 32'(out_data), 32'(model_q[0]));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, update model, compare.
    task automatic cycle(input logic mv, input logic [7:0] d, input logic ordy);
        bit do_push;
        bit do_pop;
        m_valid   = mv;
        m_s_data  = d;
        out_ready = ordy;
        @(posedge clk);
        do_push = mv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) begin
            model_q.push_back(d);
            model_cnt++;
        end
        @(negedge clk);
        compare_model();
    endtask

    task automatic add_vec(input logic mv, input logic [7:0] d, input logic ordy,
                           input logic ev, input logic [7:0] ed, input int el, input logic esr);
        vec_t v;
        v.mv = mv; v.d = d; v.ordy = ordy; v.ev = ev; v.ed = ed; v.el = el; v.esr = esr;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_cnt = 0;
        nrst      = 1'b0;
        m_valid   = 1'b0;
        m_s_data  = 8'h00;
        out_ready = 1'b0;

        // Single byte, fill to full, held byte rejected, drain, wrap-around refill and drain.
        add_vec(1, 8'hA5, 0, 1, 8'hA5, 1, 1);
        add_vec(0, 8'h00, 1, 0, 8'h00, 0, 1);
        add_vec(1, 8'h01, 0, 1, 8'h01, 1, 1);
        add_vec(1, 8'h02, 0, 1, 8'h01, 2, 1);
        add_vec(1, 8'h03, 0, 1, 8'h01, 3, 1);
        add_vec(1, 8'h04, 0, 1, 8'h01, 4, 0);
        add_vec(1, 8'h05, 0, 1, 8'h01, 4, 0);
        add_vec(0, 8'h00, 1, 1, 8'h02, 3, 1);
        add_vec(0, 8'h00, 1, 1, 8'h03, 2, 1);
        add_vec(0, 8'h00, 1, 1, 8'h04, 1, 1);
        add_vec(0, 8'h00, 1, 0, 8'h00, 0, 1);
        add_vec(1, 8'h10, 0, 1, 8'h10, 1, 1);
        add_vec(1, 8'h11, 0, 1, 8'h10, 2, 1);
        add_vec(1, 8'h12, 0, 1, 8'h10, 3, 1);
        add_vec(1, 8'h13, 0, 1, 8'h10, 4, 0);
        add_vec(0, 8'h00, 1, 1, 8'h11, 3, 1);
        add_vec(0, 8'h00, 1, 1, 8'h12, 2, 1);
        add_vec(0, 8'h00, 1, 1, 8'h13, 1, 1);
        add_vec(0, 8'h00, 1, 0, 8'h00, 0, 1);

        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        nrst = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].mv, vecs[i].d, vecs[i].ordy);
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("tbl%0d_level", i), 32'(level), 32'(vecs[i].el));
            check($sformatf("tbl%0d_sready", i), 32'(s_ready), 32'(vecs[i].esr));
            if (vecs[i].ev) check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
        end

        // Simultaneous push/pop at level 2 keeps level and order.
        cycle(1, 8'h20, 0);
        cycle(1, 8'h21, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'(8'h22 + i), 1);
            check("pp_level", 32'(level), 32'd2);
            check("pp_head", 32'(out_data), 32'(8'h21 + i));
        end

        // Asynchronous reset between edges at level 3 with a byte in flight.
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
        check("pre_rst_level", 32'(level), 32'd1);
        cycle(1, 8'h30, 0);
        cycle(1, 8'h31, 0);
        check("pre_rst_level3", 32'(level), 32'd3);
        m_valid  = 1'b1;
        m_s_data = 8'h77;
        #2 nrst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd1);
        check("arst_rx_count", 32'(rx_count), 32'd0);
        model_q.delete();
        model_cnt = 0;
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        cycle(0, 8'h00, 1);
        check("post_rst_empty", 32'(out_valid), 32'd0);

        // 300 accepted bytes with the consumer always ready.
        for (int i = 0; i < 300; i++) cycle(1, 8'(i), 1);
        cycle(0, 8'h00, 1);
`ifdef SLAVE_BUFFER_RXCNT_EN
        check("rx_count_300", 32'(rx_count), 32'd300);
`else
        check("rx_count_off", 32'(rx_count), 32'd0);
`endif

        // Randomized traffic with varying biases to visit full and empty often.
        for (int blk = 0; blk < 10; blk++) begin
            int unsigned pv;
            int unsigned pr;
            pv = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                cycle(($urandom_range(0, 99) < pv), 8'($urandom), ($urandom_range(0, 99) < pr));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
